// File: rtl/peripheral_wb_pkg.sv
// Shared Wishbone definitions for the slave memory: cycle/burst type codes,
// FSM state type and the end-of-burst helper.
package peripheral_wb_pkg;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_CONST   = 3'b001;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_END     = 3'b111;

   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [1:0] BTE_WRAP4   = 2'b01;
   localparam logic [1:0] BTE_WRAP8   = 2'b10;
   localparam logic [1:0] BTE_WRAP16  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_BEAT = 2'd2
   } wb_state_e;

   // Anything other than a constant or incrementing burst ends the access
   // after the current beat (classic, end-of-burst and reserved codes).
   function automatic logic wb_is_last(input logic [2:0] cti);
      return (cti != CTI_CONST) && (cti != CTI_INCR);
   endfunction

endpackage

// File: rtl/peripheral_wb_burst_addr.sv
// Next word index for a burst beat.
// Ports: idx (current word index), cti, bte -> next_idx_c (combinational).
module peripheral_wb_burst_addr
   import peripheral_wb_pkg::*;
#(
   parameter int unsigned IW    = 30,
   parameter int unsigned DEPTH = 1024
) (
   input  logic [IW-1:0] idx,
   input  logic [2:0]    cti,
   input  logic [1:0]    bte,
   output logic [IW-1:0] next_idx_c
);

   logic [IW-1:0] step;
   logic [IW-1:0] mask;

   // Bits under the mask increment and wrap; bits above it are held.
   always_comb begin
      step = idx + IW'(1);
      case (bte)
         BTE_WRAP4:  mask = IW'(3);
         BTE_WRAP8:  mask = IW'(7);
         BTE_WRAP16: mask = IW'(15);
         default:    mask = IW'(DEPTH - 1);
      endcase
      if (cti == CTI_INCR) begin
         next_idx_c = (idx & ~mask) | (step & mask);
      end else begin
         next_idx_c = idx;
      end
   end

endmodule

// File: rtl/peripheral_wb_slave_mem.sv
// Wishbone B3 slave memory with classic and registered-feedback bursts,
// programmable wait states, byte-lane writes and out-of-range error replies.
// Ports: wb_clk, wb_rst_n (async active-low); wb_adr_i/wb_dat_i/wb_sel_i/
// wb_we_i/wb_cyc_i/wb_stb_i/wb_cti_i/wb_bte_i from the master; wait_cycles
// (sampled at access start); wb_dat_o/wb_ack_o/wb_err_o registered; wb_rty_o = 0.
module peripheral_wb_slave_mem
   import peripheral_wb_pkg::*;
#(
   parameter int unsigned DW     = 32,
   parameter int unsigned AW     = 32,
   parameter int unsigned DEPTH  = 1024,
   parameter int unsigned WAIT_W = 4
) (
   input  logic              wb_clk,
   input  logic              wb_rst_n,
   input  logic [AW-1:0]     wb_adr_i,
   input  logic [DW-1:0]     wb_dat_i,
   input  logic [DW/8-1:0]   wb_sel_i,
   input  logic              wb_we_i,
   input  logic              wb_cyc_i,
   input  logic              wb_stb_i,
   input  logic [2:0]        wb_cti_i,
   input  logic [1:0]        wb_bte_i,
   input  logic [WAIT_W-1:0] wait_cycles,
   output logic [DW-1:0]     wb_dat_o,
   output logic              wb_ack_o,
   output logic              wb_err_o,
   output logic              wb_rty_o
);

   localparam int unsigned SW = DW / 8;
   localparam int unsigned BW = $clog2(SW);
   localparam int unsigned IW = AW - BW;
   localparam int unsigned MW = $clog2(DEPTH);

   logic [DW-1:0]     mem [DEPTH];

   wb_state_e         state_q, state_d;
   logic [WAIT_W-1:0] cnt_q, cnt_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic              ack_q, ack_d;
   logic              err_q, err_d;
   logic [DW-1:0]     dat_q, dat_d;

   logic [IW-1:0]     bus_idx;
   logic [IW-1:0]     next_idx;
   logic [IW-1:0]     issue_idx;
   logic              issue;
   logic              mem_we;
   logic              unused_adr_lsb;

   assign bus_idx        = wb_adr_i[AW-1:BW];
   assign unused_adr_lsb = ^wb_adr_i[BW-1:0];

   function automatic logic in_range(input logic [IW-1:0] i);
      return 64'(i) < 64'(DEPTH);
   endfunction

   peripheral_wb_burst_addr #(
      .IW    (IW),
      .DEPTH (DEPTH)
   ) u_burst_addr (
      .idx        (idx_q),
      .cti        (wb_cti_i),
      .bte        (wb_bte_i),
      .next_idx_c (next_idx)
   );

   // Next-state and output logic. A beat is "issued" when ack/err and read
   // data are registered for it; it completes on the following edge if stb
   // is still high, which is also when write data is committed.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      ack_d     = 1'b0;
      err_d     = 1'b0;
      dat_d     = '0;
      mem_we    = 1'b0;
      issue     = 1'b0;
      issue_idx = idx_q;

      case (state_q)
         ST_IDLE: begin
            if (wb_cyc_i && wb_stb_i) begin
               if (wait_cycles == '0) begin
                  issue     = 1'b1;
                  issue_idx = bus_idx;
                  state_d   = ST_BEAT;
               end else begin
                  cnt_d   = wait_cycles - WAIT_W'(1);
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (!wb_cyc_i) begin
               state_d = ST_IDLE;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - WAIT_W'(1);
            end else if (wb_stb_i) begin
               issue     = 1'b1;
               issue_idx = bus_idx;
               state_d   = ST_BEAT;
            end
         end
         ST_BEAT: begin
            if (!wb_cyc_i || err_q) begin
               state_d = ST_IDLE;
            end else if (ack_q) begin
               // stb low here leaves the issued beat pending with ack dropped
               if (wb_stb_i) begin
                  mem_we = wb_we_i;
                  if (wb_is_last(wb_cti_i)) begin
                     state_d = ST_IDLE;
                  end else begin
                     issue     = 1'b1;
                     issue_idx = next_idx;
                  end
               end
            end else if (wb_stb_i) begin
               // re-issue the pending beat after a master wait
               issue     = 1'b1;
               issue_idx = idx_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (issue) begin
         idx_d = issue_idx;
         if (in_range(issue_idx)) begin
            ack_d = 1'b1;
            dat_d = mem[issue_idx[MW-1:0]];
         end else begin
            err_d = 1'b1;
         end
      end
   end

   // Control and output registers.
   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         dat_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         dat_q   <= dat_d;
      end
   end

   // Storage with per-lane write enables; only acked (in-range) beats write.
   always_ff @(posedge wb_clk) begin
      if (mem_we) begin
         for (int unsigned b = 0; b < SW; b++) begin
            if (wb_sel_i[b]) begin
               mem[idx_q[MW-1:0]][8*b +: 8] <= wb_dat_i[8*b +: 8];
            end
         end
      end
   end

   assign wb_dat_o = dat_q;
   assign wb_ack_o = ack_q;
   assign wb_err_o = err_q;
   assign wb_rty_o = 1'b0;

endmodule
